// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from the read side of a synchronous FIFO.
// Pops one byte when idle, enabled and the FIFO is non-empty, then sends
// start, LSB-first data, optional even parity and stop bit(s).
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  // Stop bits reuse the bit counter; STOP_BITS is 1 or 2, always below DATA_WIDTH+1.
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_wrap;

  assign baud_wrap  = (baud_q == BAUD_LAST);
  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

  // State and output registers; reset forces the line idle-high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    rd_en_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (enable && !fifo_empty) begin
          state_d = S_POP;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      // FIFO pops on this edge; its data is valid during LOAD.
      S_POP: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d  = fifo_data;
        parity_d = ^fifo_data;
        tx_d     = 1'b0;
        baud_d   = '0;
        bit_d    = '0;
        state_d  = S_START;
      end

      S_START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance without parity fed by a small
// FIFO model, one instance with parity driven directly.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en_m, empty_m, rd_m, tx_m, busy_m, done_m;
  logic [7:0] data_m = 8'h00;
  logic       en_p, empty_p, rd_p, tx_p, busy_p, done_p;
  logic [7:0] data_p;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .reset(reset), .enable(en_m), .fifo_empty(empty_m), .fifo_data(data_m),
    .fifo_rd_en(rd_m), .tx(tx_m), .busy(busy_m), .tx_done(done_m)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u_dut_p (
    .clk(clk), .reset(reset), .enable(en_p), .fifo_empty(empty_p), .fifo_data(data_p),
    .fifo_rd_en(rd_p), .tx(tx_p), .busy(busy_p), .tx_done(done_p)
  );

  // Small FIFO model for the main instance: data appears the cycle after the pop edge.
  logic [7:0] mem [0:7];
  logic [2:0] wp = 3'd0;
  logic [2:0] rp = 3'd0;
  logic [3:0] cnt = 4'd0;
  logic       push_v = 1'b0;
  logic [7:0] push_d = 8'h00;
  logic       pop_m;

  assign pop_m   = rd_m && (cnt != 4'd0);
  assign empty_m = (cnt == 4'd0);

  always @(posedge clk) begin
    if (push_v) begin
      mem[wp] <= push_d;
      wp      <= wp + 3'd1;
    end
    if (pop_m) begin
      data_m <= mem[rp];
      rp     <= rp + 3'd1;
    end
    cnt <= cnt + {3'b000, push_v} - {3'b000, pop_m};
  end

  // Selected-instance view used by the shared check tasks.
  logic sel = 1'b0;
  logic s_tx, s_rd, s_busy, s_done;
  assign s_tx   = sel ? tx_p   : tx_m;
  assign s_rd   = sel ? rd_p   : rd_m;
  assign s_busy = sel ? busy_p : busy_m;
  assign s_done = sel ? done_p : done_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    push_d = b;
    push_v = 1'b1;
    @(negedge clk);
    push_v = 1'b0;
  endtask

  task automatic wait_rd(input int budget);
    int found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (s_rd === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("rd_en_seen", 32'(found), 32'd1);
  endtask

  // Quiet-line check: no pop, line high, not busy, no done pulse for n cycles.
  task automatic idle_check(input int n, input string tag);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (s_rd !== 1'b0 || s_tx !== 1'b1 || s_busy !== 1'b0 || s_done !== 1'b0) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  // Called on the sample where fifo_rd_en was seen high; checks the whole frame.
  task automatic check_frame(input logic [7:0] b, input bit par, input int drop_at);
    logic [10:0] bits;
    int          nb;
    int          cyc;
    if (par) begin
      bits = {1'b1, ^b, b, 1'b0};
      nb   = 11;
    end else begin
      bits = {2'b11, b, 1'b0};
      nb   = 10;
    end
    cyc = 0;
    @(negedge clk);
    chk("pop_rd_low", 32'(s_rd), 32'd0);
    chk("pop_tx_high", 32'(s_tx), 32'd1);
    chk("pop_busy", 32'(s_busy), 32'd1);
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        @(negedge clk);
        if (cyc == drop_at) en_m = 1'b0;
        cyc++;
        chk($sformatf("tx_bit%0d_%02h", k, b), 32'(s_tx), 32'(bits[k]));
        chk("frame_flags", 32'({s_done, s_rd, s_busy}), 32'd1);
      end
    end
    @(negedge clk);
    chk("done_pulse", 32'(s_done), 32'd1);
    chk("done_busy", 32'(s_busy), 32'd0);
    chk("done_tx", 32'(s_tx), 32'd1);
  endtask

  initial begin
    reset   = 1'b1;
    en_m    = 1'b0;
    en_p    = 1'b0;
    empty_p = 1'b1;
    data_p  = 8'h00;

    // Reset state
    tick(3);
    chk("rst_tx", 32'(tx_m), 32'd1);
    chk("rst_rd", 32'(rd_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_done", 32'(done_m), 32'd0);
    reset = 1'b0;

    // Empty FIFO, enabled: nothing happens
    en_m = 1'b1;
    idle_check(100, "idle_empty");

    // Data present but disabled: nothing happens
    en_m = 1'b0;
    push(8'hA5);
    idle_check(100, "idle_disabled");

    // Single byte 0xA5
    en_m = 1'b1;
    wait_rd(10);
    check_frame(8'hA5, 1'b0, -1);
    idle_check(10, "after_a5");

    // Back-to-back 0x3C, 0xC3 with minimum 3-cycle gap
    en_m = 1'b0;
    push(8'h3C);
    push(8'hC3);
    en_m = 1'b1;
    wait_rd(10);
    check_frame(8'h3C, 1'b0, -1);
    @(negedge clk);
    chk("b2b_rd", 32'(s_rd), 32'd1);
    check_frame(8'hC3, 1'b0, -1);
    idle_check(20, "after_b2b");

    // enable dropped during DATA: frame completes, second byte stays queued
    en_m = 1'b0;
    push(8'h5A);
    push(8'h11);
    en_m = 1'b1;
    wait_rd(10);
    check_frame(8'h5A, 1'b0, 10);
    idle_check(30, "no_pop_disabled");

    // Reset during DATA of byte 0x11: line high at once, byte discarded
    en_m = 1'b1;
    wait_rd(10);
    tick(14);
    chk("mid_frame_tx_low_bit", 32'(tx_m), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_tx", 32'(tx_m), 32'd1);
    chk("rst_async_rd", 32'(rd_m), 32'd0);
    chk("rst_async_busy", 32'(busy_m), 32'd0);
    chk("rst_async_done", 32'(done_m), 32'd0);
    tick(3);
    chk("rst_held", 32'({done_m, busy_m, rd_m, tx_m}), 32'd1);
    reset = 1'b0;
    idle_check(10, "post_reset_idle");
    push(8'h96);
    wait_rd(10);
    check_frame(8'h96, 1'b0, -1);

    // Parity instance: 0x07 -> parity 1, 0x03 -> parity 0
    sel     = 1'b1;
    data_p  = 8'h07;
    empty_p = 1'b0;
    en_p    = 1'b1;
    wait_rd(10);
    empty_p = 1'b1;
    check_frame(8'h07, 1'b1, -1);
    idle_check(10, "par_idle");
    data_p  = 8'h03;
    empty_p = 1'b0;
    wait_rd(10);
    empty_p = 1'b1;
    check_frame(8'h03, 1'b1, -1);
    idle_check(10, "par_idle2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
